serpent_xts_sector_ctrl: RTL and testbench

//  Sequences one XTS sector (N 128-bit blocks) through a single shared Serpent block-cipher core.

---
 rtl/serpent_xts_sector_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_serpent_xts_sector_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_xts_sector_ctrl.sv
// XTS sector sequencer: derives the sector tweak once, then runs each block through one Serpent core.
// Optional perf counters are enabled by defining SERPENT_XTS_CTRL_PERF_EN.
module serpent_xts_sector_ctrl #(
  parameter int unsigned BLK_W    = 5,
  parameter int unsigned CORE_TMO = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_key_valid,
  input  logic               i_start,
  input  logic [127:0]       i_tweak,
  input  logic [BLK_W-1:0]   i_nblocks,
  input  logic [127:0]       i_data,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic [127:0]       o_data,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  output logic               o_core_start,
  output logic               o_core_sel,
  output logic [127:0]       o_core_data,
  input  logic               i_core_valid,
  input  logic [127:0]       i_core_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
`ifdef SERPENT_XTS_CTRL_PERF_EN
  ,
  output logic [31:0]        o_perf_cycles,
  output logic [31:0]        o_perf_blocks
`endif
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TWK_REQ  = 3'd1;
  localparam logic [2:0] S_TWK_WAIT = 3'd2;
  localparam logic [2:0] S_BLK_IN   = 3'd3;
  localparam logic [2:0] S_DAT_REQ  = 3'd4;
  localparam logic [2:0] S_DAT_WAIT = 3'd5;
  localparam logic [2:0] S_BLK_OUT  = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  localparam int unsigned     TMO_W    = $clog2(CORE_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CORE_TMO - 1);

  logic [2:0]       r_state;
  logic [BLK_W-1:0] r_cnt;
  logic [127:0]     r_twk;
  logic [127:0]     r_core_data;
  logic [127:0]     r_data;
  logic             r_data_valid;
  logic             r_err;
  logic [TMO_W-1:0] r_tmo;

  logic [2:0]       w_state_nxt;
  logic [BLK_W-1:0] w_cnt_nxt;
  logic [127:0]     w_twk_nxt;
  logic [127:0]     w_core_data_nxt;
  logic [127:0]     w_data_nxt;
  logic             w_data_valid_nxt;
  logic             w_err_nxt;
  logic [TMO_W-1:0] w_tmo_nxt;

  logic [127:0]     w_twk_adv;
  logic             w_in_wait;
  logic             w_tmo_hit;

  // Multiply T by alpha in GF(2^128), reduction polynomial x^128 + x^7 + x^2 + x + 1.
  assign w_twk_adv = {r_twk[126:0], 1'b0} ^ (r_twk[127] ? 128'h87 : 128'h0);

  // The REQ->WAIT transition preloads the timer with 1, so the wait gives up CORE_TMO cycles
  // after the core start pulse.
  assign w_in_wait = (r_state == S_TWK_WAIT) || (r_state == S_DAT_WAIT);
  assign w_tmo_hit = w_in_wait && !i_core_valid && (r_tmo == TMO_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_twk_nxt        = r_twk;
    w_core_data_nxt  = r_core_data;
    w_data_nxt       = r_data;
    w_data_valid_nxt = r_data_valid;
    w_err_nxt        = r_err;
    w_tmo_nxt        = r_tmo;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && i_key_valid) begin
          w_err_nxt = 1'b0;
          w_cnt_nxt = i_nblocks;
          if (i_nblocks == '0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_core_data_nxt = i_tweak;
            w_state_nxt     = S_TWK_REQ;
          end
        end
      end
      S_TWK_REQ: begin
        w_tmo_nxt   = TMO_W'(1);
        w_state_nxt = S_TWK_WAIT;
      end
      S_TWK_WAIT: begin
        if (i_core_valid) begin
          w_twk_nxt   = i_core_data;
          w_state_nxt = S_BLK_IN;
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_BLK_IN: begin
        if (i_data_valid) begin
          w_core_data_nxt = i_data ^ r_twk;
          w_state_nxt     = S_DAT_REQ;
        end
      end
      S_DAT_REQ: begin
        w_tmo_nxt   = TMO_W'(1);
        w_state_nxt = S_DAT_WAIT;
      end
      S_DAT_WAIT: begin
        if (i_core_valid) begin
          w_data_nxt       = i_core_data ^ r_twk;
          w_data_valid_nxt = 1'b1;
          w_twk_nxt        = w_twk_adv;
          w_cnt_nxt        = r_cnt - 1'b1;
          w_state_nxt      = S_BLK_OUT;
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_BLK_OUT: begin
        if (i_data_ready) begin
          w_data_valid_nxt = 1'b0;
          w_state_nxt      = (r_cnt != '0) ? S_BLK_IN : S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_twk        <= '0;
      r_core_data  <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_twk        <= w_twk_nxt;
      r_core_data  <= w_core_data_nxt;
      r_data       <= w_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_err        <= w_err_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

  assign o_core_start = (r_state == S_TWK_REQ) || (r_state == S_DAT_REQ);
  assign o_core_sel   = (r_state == S_DAT_REQ) || (r_state == S_DAT_WAIT);
  assign o_core_data  = r_core_data;
  assign o_data_ready = (r_state == S_BLK_IN);
  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_FIN);
  assign o_err        = r_err;

`ifdef SERPENT_XTS_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_blocks;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_cycles <= '0;
      r_perf_blocks <= '0;
    end else begin
      if (o_busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
      if ((r_state == S_BLK_OUT) && i_data_ready && (r_perf_blocks != '1)) begin
        r_perf_blocks <= r_perf_blocks + 32'd1;
      end
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_blocks = r_perf_blocks;
`endif

endmodule

// File: tb/tb_serpent_xts_sector_ctrl.sv
// Randomized scoreboard bench for serpent_xts_sector_ctrl with a behavioural core stand-in.
module tb_serpent_xts_sector_ctrl;
  localparam int unsigned BLK_W    = 5;
  localparam int unsigned CORE_TMO = 20;
  localparam logic [127:0] K1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K2 = 128'h31415926535897932384626433832795;

  typedef struct packed { logic sel; logic [127:0] d; } core_req_t;
  typedef logic [127:0] blkq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst, i_key_valid, i_start, i_data_valid, i_data_ready, i_core_valid;
  logic [127:0] i_tweak, i_data, i_core_data;
  logic [BLK_W-1:0] i_nblocks;
  logic o_data_ready, o_data_valid, o_core_start, o_core_sel, o_busy, o_done, o_err;
  logic [127:0] o_data, o_core_data;
`ifdef SERPENT_XTS_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_blocks;
`endif

  serpent_xts_sector_ctrl #(.BLK_W(BLK_W), .CORE_TMO(CORE_TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_key_valid(i_key_valid), .i_start(i_start),
    .i_tweak(i_tweak), .i_nblocks(i_nblocks), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_data(o_data), .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready), .o_core_start(o_core_start), .o_core_sel(o_core_sel),
    .o_core_data(o_core_data), .i_core_valid(i_core_valid), .i_core_data(i_core_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef SERPENT_XTS_CTRL_PERF_EN
    , .o_perf_cycles(perf_cycles), .o_perf_blocks(perf_blocks)
`endif
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic bad(input string name, input string why);
    n_chk++;
    $display("FAIL %s: %s", name, why);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core stand-in: 1 = identity, 2 = fixed tweak 2^127 / identity data, else keyed mix.
  int cmode = 0;
  function automatic logic [127:0] core_f(input logic sel, input logic [127:0] x);
    case (cmode)
      1: return x;
      2: return sel ? x : {1'b1, 127'd0};
      default: return sel ? (({x[114:0], x[127:115]} ^ K1) + 128'd12345)
                          : ({x[63:0], x[127:64]} ^ K2);
    endcase
  endfunction

  // T * alpha as polynomial multiplication by x, reduced modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] xtimes(input logic [127:0] t);
    logic [128:0] w;
    w = {1'b0, t} << 1;
    if (w[128]) w = w ^ {1'b1, 120'd0, 8'h87};
    return w[127:0];
  endfunction

  core_req_t    exp_core[$];
  logic [127:0] exp_out[$];

  // Behavioural core: checks each request against the scoreboard, answers after lat cycles.
  int lat_lo = 1, lat_hi = 4, starts0 = 0, starts1 = 0, twk_cyc = 0;
  bit core_hang = 0, noise_en = 1;
  initial begin
    int pend;
    logic [127:0] res, cap;
    logic rst_s;
    core_req_t e;
    pend = -1; res = '0; cap = '0;
    i_core_valid = 1'b0; i_core_data = '0;
    forever begin
      @(posedge clk); rst_s = i_rst; #1;
      i_core_valid = 1'b0;
      if (rst_s) pend = -1;
      else begin
        if (pend > 0) begin
          chk("core_data_stable", o_core_data, cap);
          pend--;
          if (pend == 0) begin
            i_core_valid = 1'b1; i_core_data = res; pend = -1;
          end
        end
        if (o_core_start) begin
          if (exp_core.size() == 0) bad("core_start", "unexpected core start");
          else begin
            e = exp_core.pop_front();
            chk("core_sel", o_core_sel, e.sel);
            chk("core_in", o_core_data, e.d);
          end
          if (o_core_sel) starts1++;
          else begin starts0++; twk_cyc = cyc; end
          cap = o_core_data;
          res = core_f(o_core_sel, o_core_data);
          pend = core_hang ? -1 : $urandom_range(lat_hi, lat_lo);
        end else if (pend < 0 && !i_core_valid && noise_en && !core_hang &&
                     $urandom_range(7) == 0) begin
          i_core_valid = 1'b1; i_core_data = rand128();
        end
      end
    end
  end

  int rdy_pct = 100;
  initial begin
    i_data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_data_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Output monitor: pops the scoreboard on every accepted output block.
  int last_acc = 0, done_cnt = 0, done_cyc = 0;
  initial begin
    logic stall;
    logic [127:0] hold, e;
    stall = 1'b0; hold = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin stall = 1'b0; continue; end
      if (stall) begin
        chk("hold_valid", o_data_valid, 1'b1);
        chk("hold_data", o_data, hold);
      end
      if (o_data_valid) begin
        chk("ready_valid_excl", o_data_ready, 1'b0);
        if (i_data_ready) begin
          if (exp_out.size() == 0) bad("data_out", "unexpected output block");
          else begin e = exp_out.pop_front(); chk("data_out", o_data, e); end
          last_acc = cyc; stall = 1'b0;
        end else begin
          stall = 1'b1; hold = o_data;
        end
      end else stall = 1'b0;
      if (o_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_sector(input logic [127:0] tw, input int n);
    i_tweak = tw; i_nblocks = BLK_W'(n); i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic feed_block(input logic [127:0] b, input bit poke, output bit ok);
    int k;
    repeat ($urandom_range(2)) tick();
    i_data = b; i_data_valid = 1'b1;
    if (poke) begin
      i_start = 1'b1; i_nblocks = BLK_W'($urandom); i_key_valid = 1'($urandom_range(1));
    end
    k = 0; ok = 1'b0;
    while (!ok && k < 400) begin @(negedge clk); ok = o_data_ready; k++; end
    tick();
    i_data_valid = 1'b0; i_start = 1'b0; i_data = rand128();
  endtask

  function automatic blkq_t rand_blocks(input int n);
    blkq_t q;
    for (int i = 0; i < n; i++) q.push_back(rand128());
    return q;
  endfunction

  // Builds the expected core requests and outputs from the XTS rules, then drives the sector.
  task automatic run_sector(input logic [127:0] tw, input blkq_t blk, input bit poke);
    logic [127:0] t, x;
    int n, k, s, st;
    bit ok;
    n = blk.size();
    if (n > 0) begin
      exp_core.push_back('{sel: 1'b0, d: tw});
      t = core_f(1'b0, tw);
      for (int i = 0; i < n; i++) begin
        x = blk[i] ^ t;
        exp_core.push_back('{sel: 1'b1, d: x});
        exp_out.push_back(core_f(1'b1, x) ^ t);
        t = xtimes(t);
      end
    end
    done_cnt = 0; s = cyc; st = starts0 + starts1;
    start_sector(tw, n);
    for (int i = 0; i < n; i++) begin
      feed_block(blk[i], poke, ok);
      if (!ok) begin bad("input_accept", "o_data_ready never rose"); break; end
    end
    i_key_valid = 1'b1;
    k = 0;
    while (done_cnt == 0 && k < 400) begin @(negedge clk); k++; end
    if (done_cnt == 0) bad("done", "o_done never pulsed");
    if (n == 0) begin
      chk("zero_done_cycle", done_cyc, s + 1);
      chk("zero_no_core", starts0 + starts1, st);
    end else begin
      chk("done_after_accept", done_cyc, last_acc + 1);
    end
    tick();
    @(negedge clk);
    chk("done_pulse_count", done_cnt, 1);
    chk("idle_after_done", o_busy, 1'b0);
    chk("err_clear", o_err, 1'b0);
    chk("out_drained", exp_out.size(), 0);
    chk("core_drained", exp_core.size(), 0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {o_busy, o_done, o_err, o_data_valid, o_data_ready, o_core_start,
                         o_core_sel}, '0);
    chk({tag, "_data"}, o_data, '0);
    chk({tag, "_core_data"}, o_core_data, '0);
  endtask

  initial begin
    int k, target;
    bit ok;
    logic [127:0] tw;
    blkq_t q;
    i_rst = 1'b1; i_key_valid = 1'b1; i_start = 1'b0; i_tweak = '0; i_nblocks = '0;
    i_data = '0; i_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    tick();

    // Identity core, zero tweak: output equals input.
    cmode = 1;
    q = '{{16{8'hA5}}};
    run_sector('0, q, 1'b0);

    // Tweak pass returns 2^127, so T walks 0x87 then 0x10E across the data passes.
    cmode = 2;
    run_sector(rand128(), rand_blocks(3), 1'b0);

    // Output backpressure on block 0.
    cmode = 0; rdy_pct = 0;
    fork
      run_sector(rand128(), rand_blocks(2), 1'b0);
      begin
        int kk, s;
        kk = 0;
        while (!o_data_valid && kk < 200) begin @(negedge clk); kk++; end
        chk("bp_valid_seen", o_data_valid, 1'b1);
        s = starts0 + starts1;
        repeat (10) begin @(negedge clk); chk("bp_no_ready", o_data_ready, 1'b0); end
        chk("bp_no_extra_start", starts0 + starts1, s);
        rdy_pct = 100;
      end
    join
    tick();

    // Empty sector.
    q = {};
    run_sector(rand128(), q, 1'b0);

    // Start without a valid key is ignored.
    i_key_valid = 1'b0;
    start_sector(rand128(), 3);
    @(negedge clk);
    chk("nokey_ignored", o_busy, 1'b0);
    tick();
    i_key_valid = 1'b1;

    // Core never answers: timeout raises o_err and o_done.
    core_hang = 1;
    tw = rand128();
    exp_core.push_back('{sel: 1'b0, d: tw});
    done_cnt = 0;
    start_sector(tw, 2);
    k = 0;
    while (done_cnt == 0 && k < 200) begin @(negedge clk); k++; end
    if (done_cnt == 0) bad("tmo_done", "o_done never pulsed after timeout");
    chk("tmo_done_cycle", done_cyc - twk_cyc, CORE_TMO);
    chk("tmo_err", o_err, 1'b1);
    tick();
    @(negedge clk);
    chk("tmo_err_sticky", o_err, 1'b1);
    chk("tmo_idle", o_busy, 1'b0);
    chk("tmo_done_once", done_cnt, 1);
    chk("tmo_core_drained", exp_core.size(), 0);
    tick();
    core_hang = 0;
    start_sector(rand128(), 0);
    @(negedge clk);
    chk("err_cleared_by_start", o_err, 1'b0);
    chk("err_clear_done", o_done, 1'b1);
    tick();

    // Reset during DAT_WAIT of block 1 of 3, then a fresh sector.
    cmode = 0; lat_lo = 6; lat_hi = 6;
    q = rand_blocks(3);
    tw = rand128();
    exp_core.push_back('{sel: 1'b0, d: tw});
    begin
      logic [127:0] t, x;
      t = core_f(1'b0, tw);
      for (int i = 0; i < 3; i++) begin
        x = q[i] ^ t;
        exp_core.push_back('{sel: 1'b1, d: x});
        exp_out.push_back(core_f(1'b1, x) ^ t);
        t = xtimes(t);
      end
    end
    target = starts1 + 2;
    start_sector(tw, 3);
    feed_block(q[0], 1'b0, ok);
    if (!ok) bad("rst_feed0", "block 0 not accepted");
    feed_block(q[1], 1'b0, ok);
    if (!ok) bad("rst_feed1", "block 1 not accepted");
    k = 0;
    while (starts1 < target && k < 50) begin @(negedge clk); k++; end
    if (starts1 < target) bad("rst_sync", "block 1 data pass never started");
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_out.delete();
    exp_core.delete();
    @(negedge clk);
    check_zero("midrst");
    tick();
    lat_lo = 1; lat_hi = 4;
    run_sector(rand128(), rand_blocks(4), 1'b0);

    // Randomized sectors with backpressure, core noise and ignored mid-sector starts.
    rdy_pct = 70; lat_lo = 1; lat_hi = 5;
    for (int r = 0; r < 6; r++) begin
      run_sector(rand128(), rand_blocks($urandom_range(6, 1)), 1'(r % 2));
    end

    // Largest sector for this block-count width.
    rdy_pct = 100; lat_lo = 1; lat_hi = 2;
    run_sector(rand128(), rand_blocks(31), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
